// File: rtl/dffrs_vector_sequencer_pkg.sv
// Shared types, pin/vector constants and the DFFRS expected-value function
// used by the vector sequencer and its reference model.
package dffrs_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  // Bit positions of the cell pins inside a 4-bit vector index.
  localparam int unsigned VEC_D  = 3;
  localparam int unsigned VEC_RN = 2;
  localparam int unsigned VEC_SN = 1;
  localparam int unsigned VEC_CK = 0;

  localparam logic [3:0] VEC_LAST = 4'hF;

  localparam logic PIN_D_INACTIVE  = 1'b0;
  localparam logic PIN_RN_INACTIVE = 1'b1;
  localparam logic PIN_SN_INACTIVE = 1'b1;
  localparam logic PIN_CK_INACTIVE = 1'b0;

  // Packed in the same D/RN/SN/CK order as a vector index.
  localparam logic [3:0] PIN_RST_VEC = {PIN_D_INACTIVE, PIN_RN_INACTIVE,
                                        PIN_SN_INACTIVE, PIN_CK_INACTIVE};

  function automatic logic [1:0] dffrs_expected(input logic rn, input logic sn,
                                                input logic d, input logic ck_rise,
                                                input logic prev_q,
                                                input logic both_low_q,
                                                input logic both_low_qn);
    logic [1:0] pair;
    logic       q;
    q = prev_q;
    if (!rn) begin
      q = 1'b0;
    end else if (!sn) begin
      q = 1'b1;
    end else if (ck_rise) begin
      q = d;
    end
    pair = {q, ~q};
    if (!rn && !sn) begin
      pair = {both_low_q, both_low_qn};
    end
    return pair;
  endfunction

endpackage

// File: rtl/dffrs_vector_sequencer_if.sv
// Pin bundle between the sequencer and one DFFRS cell.
interface dffrs_vector_sequencer_if;
  logic d;
  logic rn;
  logic sn;
  logic ck;
  logic q;
  logic qn;

  modport master (output d, output rn, output sn, output ck, input q, input qn);
  modport slave  (input d, input rn, input sn, input ck, output q, output qn);
endinterface

// File: rtl/dffrs_vector_sequencer_ref.sv
// Registered DFFRS reference model: updates its expected {Q,QN} on the same
// edge the sequencer drives a new vector.
module dffrs_ref_model
  import dffrs_seq_pkg::*;
#(
  parameter logic BOTH_LOW_Q  = 1'b1,
  parameter logic BOTH_LOW_QN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] vec_i,
  input  logic       prev_ck_i,
  output logic       exp_q_o,
  output logic       exp_qn_o
);

  logic q_q;
  logic qn_q;
  logic ck_rise;

  assign ck_rise = ~prev_ck_i & vec_i[VEC_CK];

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= 1'b0;
      qn_q <= 1'b1;
    end else if (load_i) begin
      {q_q, qn_q} <= dffrs_expected(vec_i[VEC_RN], vec_i[VEC_SN], vec_i[VEC_D],
                                    ck_rise, q_q, BOTH_LOW_Q, BOTH_LOW_QN);
    end
  end

  assign exp_q_o  = q_q;
  assign exp_qn_o = qn_q;

endmodule

// File: rtl/dffrs_vector_sequencer.sv
// On-clock stimulus sequencer for one DFFRS cell: walks all 16 pin vectors,
// samples Q/QN after a settle window and accumulates pass/fail results.
module dffrs_vector_sequencer
  import dffrs_seq_pkg::*;
#(
  parameter int unsigned SETTLE      = 2,
  parameter logic        BOTH_LOW_Q  = 1'b1,
  parameter logic        BOTH_LOW_QN = 1'b1
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  output logic       D_O,
  output logic       RN_O,
  output logic       SN_O,
  output logic       CK_O,
  input  logic       Q_I,
  input  logic       QN_I,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_CNT,
  output logic [3:0] FAIL_VEC,
  output logic [3:0] VEC_IDX
);

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

  seq_state_e state_q;
  logic [3:0] vec_q;
  logic [3:0] pins_q;
  logic [3:0] cnt_q;
  logic [4:0] err_q;
  logic [3:0] fail_vec_q;
  logic       first_fail_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic       accept;
  logic [3:0] vec_d;
  logic       prev_ck_d;
  logic       load_d;
  logic       exp_q;
  logic       exp_qn;
  logic       mismatch;

  assign accept    = START && (state_q == ST_IDLE || state_q == ST_DONE);
  assign vec_d     = accept ? 4'd0 : vec_q + 4'd1;
  // Vector 0 has no predecessor, so the model sees the clock pin as low.
  assign prev_ck_d = accept ? 1'b0 : pins_q[VEC_CK];
  assign load_d    = accept || (state_q == ST_SAMPLE && vec_q != VEC_LAST);
  assign mismatch  = {Q_I, QN_I} != {exp_q, exp_qn};

  dffrs_ref_model #(
    .BOTH_LOW_Q (BOTH_LOW_Q),
    .BOTH_LOW_QN(BOTH_LOW_QN)
  ) u_ref (
    .clk      (CK),
    .rst      (RST),
    .load_i   (load_d),
    .vec_i    (vec_d),
    .prev_ck_i(prev_ck_d),
    .exp_q_o  (exp_q),
    .exp_qn_o (exp_qn)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      vec_q        <= 4'd0;
      pins_q       <= PIN_RST_VEC;
      cnt_q        <= 4'd0;
      err_q        <= 5'd0;
      fail_vec_q   <= 4'd0;
      first_fail_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state_q      <= ST_SETTLE;
            vec_q        <= vec_d;
            pins_q       <= vec_d;
            cnt_q        <= CNT_RELOAD;
            err_q        <= 5'd0;
            fail_vec_q   <= 4'd0;
            first_fail_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_q <= err_q + 5'd1;
            if (!first_fail_q) begin
              first_fail_q <= 1'b1;
              fail_vec_q   <= vec_q;
            end
          end
          if (vec_q != VEC_LAST) begin
            state_q <= ST_SETTLE;
            vec_q   <= vec_d;
            pins_q  <= vec_d;
            cnt_q   <= CNT_RELOAD;
          end else begin
            // Last sample: fold in this vector's outcome before reporting.
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == 5'd0) && !mismatch;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign D_O      = pins_q[VEC_D];
  assign RN_O     = pins_q[VEC_RN];
  assign SN_O     = pins_q[VEC_SN];
  assign CK_O     = pins_q[VEC_CK];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fail_vec_q;
  assign VEC_IDX  = vec_q;

endmodule

// File: tb/tb_dffrs_vector_sequencer.sv
// Directed bench: three sequencers (SETTLE 2, 1, 15) each driving a behavioural
// DFFRS cell that can be made ideal, Q stuck-at-0, or deaf to its clock.
module tb_dffrs_vector_sequencer;

  logic CK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;
  int   fault_mode = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  logic [2:0] busy_w;
  logic [2:0] done_w;
  logic [2:0] pass_w;
  logic [4:0] err_w  [3];
  logic [3:0] fail_w [3];
  logic [3:0] vidx_w [3];
  int         done_cyc [3];

  always #5 CK = ~CK;

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 15;
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int unsigned S = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;
      dffrs_vector_sequencer_if pif ();
      logic st_q = 1'b0;
      logic q_ideal;
      logic qn_ideal;

      dffrs_vector_sequencer #(
        .SETTLE     (S),
        .BOTH_LOW_Q (1'b1),
        .BOTH_LOW_QN(1'b1)
      ) dut (
        .CK      (CK),
        .RST     (RST),
        .START   (START),
        .D_O     (pif.d),
        .RN_O    (pif.rn),
        .SN_O    (pif.sn),
        .CK_O    (pif.ck),
        .Q_I     (pif.q),
        .QN_I    (pif.qn),
        .BUSY    (busy_w[gi]),
        .DONE    (done_w[gi]),
        .PASS    (pass_w[gi]),
        .ERR_CNT (err_w[gi]),
        .FAIL_VEC(fail_w[gi]),
        .VEC_IDX (vidx_w[gi])
      );

      always @(posedge pif.ck or negedge pif.rn or negedge pif.sn) begin
        if (!pif.rn) st_q <= 1'b0;
        else if (!pif.sn) st_q <= 1'b1;
        else if (fault_mode != 2) st_q <= pif.d;
      end

      always_comb begin
        q_ideal  = st_q;
        qn_ideal = ~st_q;
        if (!pif.rn && !pif.sn) begin
          q_ideal  = 1'b1;
          qn_ideal = 1'b1;
        end else if (!pif.rn) begin
          q_ideal  = 1'b0;
          qn_ideal = 1'b1;
        end else if (!pif.sn) begin
          q_ideal  = 1'b1;
          qn_ideal = 1'b0;
        end
      end

      assign pif.q  = (fault_mode == 1) ? 1'b0 : q_ideal;
      assign pif.qn = qn_ideal;
    end
  endgenerate

  logic [3:0] pins0;
  logic [1:0] qq0;
  assign pins0 = {g_inst[0].pif.d, g_inst[0].pif.rn, g_inst[0].pif.sn, g_inst[0].pif.ck};
  assign qq0   = {g_inst[0].pif.q, g_inst[0].pif.qn};

  typedef struct {
    logic [3:0] v;
    logic       q;
    logic       qn;
  } vec_t;

  typedef struct {
    int         fault;
    logic [4:0] err;
    logic [3:0] fvec;
    logic       pass;
  } run_t;

  vec_t vecs [16];
  run_t runs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_all(input int base);
    for (int i = 0; i < 3; i++) done_cyc[i] = -1;
    for (int c = base + 1; c <= base + 300; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (done_w[i] && done_cyc[i] < 0) done_cyc[i] = c;
      end
      if (done_cyc[0] >= 0 && done_cyc[1] >= 0 && done_cyc[2] >= 0) break;
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] err,
                           input logic [3:0] fvec, input logic pass);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_i%0d_done_cycle", tag, i), 32'(done_cyc[i]), 32'(16 * (settle_of(i) + 1)));
      chk($sformatf("%s_i%0d_err_cnt", tag, i), 32'(err_w[i]), 32'(err));
      chk($sformatf("%s_i%0d_fail_vec", tag, i), 32'(fail_w[i]), 32'(fvec));
      chk($sformatf("%s_i%0d_pass", tag, i), 32'(pass_w[i]), 32'(pass));
      chk($sformatf("%s_i%0d_busy", tag, i), 32'(busy_w[i]), 32'(0));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pins"}, 32'(pins0), 32'(4'b0110));
    chk({tag, "_err"}, 32'(err_w[0]), 32'(0));
    chk({tag, "_fail_vec"}, 32'(fail_w[0]), 32'(0));
    chk({tag, "_vec_idx"}, 32'(vidx_w[0]), 32'(0));
    chk({tag, "_busy_all"}, 32'(busy_w), 32'(0));
    chk({tag, "_done_all"}, 32'(done_w), 32'(0));
    chk({tag, "_pass_all"}, 32'(pass_w), 32'(0));
  endtask

  initial begin
    // Expected cell response per vector, worked out by hand from D/RN/SN/CK.
    vecs[0]  = '{4'd0,  1'b1, 1'b1};
    vecs[1]  = '{4'd1,  1'b1, 1'b1};
    vecs[2]  = '{4'd2,  1'b0, 1'b1};
    vecs[3]  = '{4'd3,  1'b0, 1'b1};
    vecs[4]  = '{4'd4,  1'b1, 1'b0};
    vecs[5]  = '{4'd5,  1'b1, 1'b0};
    vecs[6]  = '{4'd6,  1'b1, 1'b0};
    vecs[7]  = '{4'd7,  1'b0, 1'b1};
    vecs[8]  = '{4'd8,  1'b1, 1'b1};
    vecs[9]  = '{4'd9,  1'b1, 1'b1};
    vecs[10] = '{4'd10, 1'b0, 1'b1};
    vecs[11] = '{4'd11, 1'b0, 1'b1};
    vecs[12] = '{4'd12, 1'b1, 1'b0};
    vecs[13] = '{4'd13, 1'b1, 1'b0};
    vecs[14] = '{4'd14, 1'b1, 1'b0};
    vecs[15] = '{4'd15, 1'b1, 1'b0};

    // Stuck-at-0 misses every vector expecting Q=1 (11 of them, first is v0).
    runs[0] = '{0, 5'd0,  4'd0, 1'b1};
    runs[1] = '{1, 5'd11, 4'd0, 1'b0};
    runs[2] = '{2, 5'd1,  4'd7, 1'b0};

    repeat (3) tick();
    check_reset("reset");
    RST = 1'b0;
    tick();

    // Walk instance 0 vector by vector, checking pins and cell response.
    fault_mode = 0;
    pulse_start();
    chk("walk_busy_after_start", 32'(busy_w[0]), 32'(1));
    for (int v = 0; v < 16; v++) begin
      repeat ((v == 0) ? 2 : 3) tick();
      chk($sformatf("walk_v%0d_pins", v), 32'(pins0), 32'(vecs[v].v));
      chk($sformatf("walk_v%0d_idx", v), 32'(vidx_w[0]), 32'(vecs[v].v));
      chk($sformatf("walk_v%0d_qqn", v), 32'(qq0), 32'({vecs[v].q, vecs[v].qn}));
    end
    chk("walk_done_before_48", 32'(done_w[0]), 32'(0));
    tick();
    chk("walk_done_at_48", 32'(done_w[0]), 32'(1));
    chk("walk_busy_at_48", 32'(busy_w[0]), 32'(0));
    chk("walk_pass", 32'(pass_w[0]), 32'(1));
    chk("walk_pins_hold_v15", 32'(pins0), 32'(4'hF));
    wait_all(48);

    for (int r = 0; r < 3; r++) begin
      fault_mode = runs[r].fault;
      pulse_start();
      wait_all(0);
      check_all($sformatf("run%0d_fault%0d", r, runs[r].fault), runs[r].err, runs[r].fvec, runs[r].pass);
    end

    // START while busy is ignored; START in DONE restarts and clears results.
    fault_mode = 1;
    pulse_start();
    repeat (9) tick();
    pulse_start();
    wait_all(10);
    check_all("retrig", 5'd11, 4'd0, 1'b0);
    pulse_start();
    chk("restart_done_drops", 32'(done_w[0]), 32'(0));
    chk("restart_err_cleared", 32'(err_w[0]), 32'(0));
    chk("restart_busy", 32'(busy_w[0]), 32'(1));
    wait_all(0);
    check_all("restart", 5'd11, 4'd0, 1'b0);

    // Reset mid-run discards everything; the next run is clean.
    fault_mode = 0;
    pulse_start();
    repeat (19) tick();
    RST = 1'b1;
    tick();
    check_reset("midrst");
    RST = 1'b0;
    tick();
    pulse_start();
    wait_all(0);
    check_all("after_rst", 5'd0, 4'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
